// File: rtl/mic_vol_pkg.sv
// Shared definitions for the mic volume meter.
//   - RGB565 colour constants used by the palettes
//   - palette_t: the five colours one theme needs (low/mid/high zone, background, peak marker)
//   - theme_palette(): maps the 2-bit theme switch to a palette
//   - border coordinates for the three nested frames on the 96x64 OLED
package mic_vol_pkg;

  localparam logic [15:0] C_BLACK   = 16'h0000;
  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_ORANGE  = 16'hFC00;
  localparam logic [15:0] C_PURPLE  = 16'h8204;
  localparam logic [15:0] C_SKY     = 16'h5FFF;

  typedef struct packed {
    logic [15:0] low;
    logic [15:0] mid;
    logic [15:0] high;
    logic [15:0] bg;
    logic [15:0] marker;
  } palette_t;

  // Frame edges: each border is a one-pixel rectangle between LO and the X/Y HI edge.
  localparam int OUTER_LO   = 1;
  localparam int OUTER_HI_X = 94;
  localparam int OUTER_HI_Y = 62;
  localparam int MID_LO     = 3;
  localparam int MID_HI_X   = 92;
  localparam int MID_HI_Y   = 60;
  localparam int INNER_LO   = 5;
  localparam int INNER_HI_X = 90;
  localparam int INNER_HI_Y = 58;

  localparam int SCREEN_MAX_X = 95;
  localparam int SCREEN_MAX_Y = 63;

  function automatic palette_t theme_palette(input logic [1:0] theme_sw);
    palette_t p;
    case (theme_sw)
      2'b00:   p = '{low: C_GREEN,   mid: C_YELLOW,  high: C_RED,     bg: C_BLACK, marker: C_WHITE};
      2'b01:   p = '{low: C_MAGENTA, mid: C_BLUE,    high: C_ORANGE,  bg: C_WHITE, marker: C_BLACK};
      2'b10:   p = '{low: C_YELLOW,  mid: C_GREEN,   high: C_MAGENTA, bg: C_BLUE,  marker: C_WHITE};
      default: p = '{low: C_PURPLE,  mid: C_MAGENTA, high: C_BLUE,    bg: C_SKY,   marker: C_BLACK};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vu_peak_tracker.sv
// Smoothed level and peak-hold state for the volume meter.
//   clk, reset   : clock, asynchronous active-high reset
//   sample_tick  : one-cycle strobe that advances the state
//   freeze       : 1 masks sample_tick (level, peak and hold counter stay put)
//   volume       : raw unsigned volume
//   level        : smoothed level (instant attack, 1 step per tick release)
//   peak         : peak-hold value (holds HOLD_TICKS ticks, then decays 1 per tick)
module vu_peak_tracker #(
  parameter int VOL_W      = 5,
  parameter int HOLD_TICKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             freeze,
  input  logic [VOL_W-1:0] volume,
  output logic [VOL_W-1:0] level,
  output logic [VOL_W-1:0] peak
);

  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic [VOL_W-1:0] level_q, level_d;
  logic [VOL_W-1:0] peak_q, peak_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [VOL_W-1:0] level_dec;

  always_comb begin
    level_d   = level_q;
    peak_d    = peak_q;
    hold_d    = hold_q;
    // Release step clamped at zero; on the release path volume <= level_q,
    // so max(level-1, volume) never undershoots the live input.
    level_dec = (level_q != '0) ? level_q - 1'b1 : '0;
    if (sample_tick && !freeze) begin
      if (volume > level_q) level_d = volume;
      else                  level_d = (level_dec > volume) ? level_dec : volume;

      // Peak follows the new level, not the old one.
      if (level_d >= peak_q) begin
        peak_d = level_d;
        hold_d = HW'(HOLD_TICKS);
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else if (peak_q != '0) begin
        peak_d = peak_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
    end else begin
      level_q <= level_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
    end
  end

  assign level = level_q;
  assign peak  = peak_q;

endmodule

// File: rtl/mic_volume_meter.sv
// Clocked mic volume display for a 96x64 RGB565 OLED.
//   clk, reset   : clock, asynchronous active-high reset
//   sample_tick  : advances smoothed level / peak-hold state
//   freeze       : holds level, peak and hold counter
//   volume       : raw unsigned mic volume
//   theme_sw     : palette select
//   x, y         : pixel being requested by the OLED driver
//   oled_data    : registered colour for the (x,y,theme_sw) of the previous cycle
// Rendering: three nested borders, then the peak marker, then lit bars, else background.
module mic_volume_meter
  import mic_vol_pkg::*;
#(
  parameter int N_BARS     = 6,
  parameter int VOL_W      = 5,
  parameter int HOLD_TICKS = 3,
  parameter int X0         = 18,
  parameter int BAR_LEN    = 60,
  parameter int Y0         = 17,
  parameter int BAR_H      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             freeze,
  input  logic [VOL_W-1:0] volume,
  input  logic [1:0]       theme_sw,
  input  logic [6:0]       x,
  input  logic [5:0]       y,
  output logic [15:0]      oled_data
);

  localparam int STEP = (2 ** VOL_W + N_BARS - 1) / N_BARS;
  localparam int LW   = VOL_W + 4;

  logic [VOL_W-1:0] level, peak;

  vu_peak_tracker #(
    .VOL_W      (VOL_W),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .freeze      (freeze),
    .volume      (volume),
    .level       (level),
    .peak        (peak)
  );

  palette_t    pal;
  int          xi, yi, pk, row_lo;
  logic        in_range, outer_hit, mid_hit, inner_hit, in_bar_x;
  logic        marker_hit, bar_hit, in_slot;
  logic [15:0] bar_col;
  logic [15:0] oled_d, oled_q;

  always_comb begin
    pal        = theme_palette(theme_sw);
    xi         = int'(x);
    yi         = int'(y);
    in_range   = (xi <= SCREEN_MAX_X) && (yi <= SCREEN_MAX_Y);
    outer_hit  = (((xi == OUTER_LO) || (xi == OUTER_HI_X)) && (yi >= OUTER_LO) && (yi <= OUTER_HI_Y)) ||
                 (((yi == OUTER_LO) || (yi == OUTER_HI_Y)) && (xi >= OUTER_LO) && (xi <= OUTER_HI_X));
    mid_hit    = (((xi == MID_LO) || (xi == MID_HI_X)) && (yi >= MID_LO) && (yi <= MID_HI_Y)) ||
                 (((yi == MID_LO) || (yi == MID_HI_Y)) && (xi >= MID_LO) && (xi <= MID_HI_X));
    inner_hit  = (((xi == INNER_LO) || (xi == INNER_HI_X)) && (yi >= INNER_LO) && (yi <= INNER_HI_Y)) ||
                 (((yi == INNER_LO) || (yi == INNER_HI_Y)) && (xi >= INNER_LO) && (xi <= INNER_HI_X));
    in_bar_x   = (xi >= X0) && (xi <= X0 + BAR_LEN - 1);
    // pk is only meaningful when peak != 0; STEP*N_BARS >= 2^VOL_W keeps it below N_BARS.
    pk         = (int'(peak) - 1) / STEP;
    marker_hit = 1'b0;
    bar_hit    = 1'b0;
    bar_col    = pal.bg;
    row_lo     = 0;
    in_slot    = 1'b0;
    for (int i = 0; i < N_BARS; i++) begin
      row_lo  = Y0 + i * BAR_H;
      // The last row of every slot is a background gap.
      in_slot = in_bar_x && (yi >= row_lo) && (yi <= row_lo + BAR_H - 2);
      if (in_slot && (peak != '0) && (i == pk)) marker_hit = 1'b1;
      if (in_slot && (LW'(level) > LW'(i * STEP))) begin
        bar_hit = 1'b1;
        if (i < N_BARS / 3)          bar_col = pal.low;
        else if (i < 2 * N_BARS / 3) bar_col = pal.mid;
        else                         bar_col = pal.high;
      end
    end

    if (!in_range)       oled_d = pal.bg;
    else if (outer_hit)  oled_d = pal.low;
    else if (mid_hit)    oled_d = pal.mid;
    else if (inner_hit)  oled_d = pal.high;
    else if (marker_hit) oled_d = pal.marker;
    else if (bar_hit)    oled_d = bar_col;
    else                 oled_d = pal.bg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) oled_q <= 16'h0000;
    else       oled_q <= oled_d;
  end

  assign oled_data = oled_q;

endmodule

// File: tb/tb_mic_volume_meter.sv
module tb_mic_volume_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        freeze = 1'b0;
  logic [4:0]  volume = '0;
  logic [1:0]  theme_sw = '0;
  logic [6:0]  x = '0;
  logic [5:0]  y = '0;
  logic [15:0] oled_data;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  // Reference state of the meter, advanced in lockstep with the stimulus.
  int m_level = 0;
  int m_peak  = 0;
  int m_hold  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mic_volume_meter dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .freeze      (freeze),
    .volume      (volume),
    .theme_sw    (theme_sw),
    .x           (x),
    .y           (y),
    .oled_data   (oled_data)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %04h expected %04h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_level = 0;
    m_peak  = 0;
    m_hold  = 0;
  endtask

  task automatic model_tick(input int vol);
    if (vol > m_level)            m_level = vol;
    else if (m_level - 1 > vol)   m_level = m_level - 1;
    else                          m_level = vol;
    if (m_level >= m_peak) begin
      m_peak = m_level;
      m_hold = 3;
    end else if (m_hold > 0) m_hold--;
    else if (m_peak > 0)     m_peak--;
  endtask

  function automatic logic [15:0] ref_pixel(input int px, input int py, input int th);
    logic [15:0] lo, mi, hi, bg, mk;
    int bar;
    case (th)
      0:       begin lo = 16'h07E0; mi = 16'hFFE0; hi = 16'hF800; bg = 16'h0000; mk = 16'hFFFF; end
      1:       begin lo = 16'hF81F; mi = 16'h001F; hi = 16'hFC00; bg = 16'hFFFF; mk = 16'h0000; end
      2:       begin lo = 16'hFFE0; mi = 16'h07E0; hi = 16'hF81F; bg = 16'h001F; mk = 16'hFFFF; end
      default: begin lo = 16'h8204; mi = 16'hF81F; hi = 16'h001F; bg = 16'h5FFF; mk = 16'h0000; end
    endcase
    if (px > 95 || py > 63) return bg;
    if (((px == 1 || px == 94) && py >= 1 && py <= 62) || ((py == 1 || py == 62) && px >= 1 && px <= 94)) return lo;
    if (((px == 3 || px == 92) && py >= 3 && py <= 60) || ((py == 3 || py == 60) && px >= 3 && px <= 92)) return mi;
    if (((px == 5 || px == 90) && py >= 5 && py <= 58) || ((py == 5 || py == 58) && px >= 5 && px <= 90)) return hi;
    bar = -1;
    if (px >= 18 && px <= 77 && py >= 17) begin
      if ((py - 17) / 5 < 6 && (py - 17) % 5 != 4) bar = (py - 17) / 5;
    end
    if (bar >= 0) begin
      if (m_peak > 0 && bar == (m_peak - 1) / 6) return mk;
      if (m_level > bar * 6) return (bar < 2) ? lo : (bar < 4) ? mi : hi;
    end
    return bg;
  endfunction

  // ---------------- driver ----------------
  // One cycle: compare the pixel requested last cycle, then drive the next one.
  // want < 0 takes the expectation from the model; otherwise it is a fixed value.
  task automatic step(input int px, input int py, input int th, input logic tk, input logic fz,
                      input int vol, input int want, input string tag);
    @(negedge clk);
    if (exp_q.size() > 0) check(tag_q.pop_front(), oled_data, exp_q.pop_front());
    x           = 7'(px);
    y           = 6'(py);
    theme_sw    = 2'(th);
    sample_tick = tk;
    freeze      = fz;
    volume      = 5'(vol);
    // The output register samples the state from before this cycle's tick.
    exp_q.push_back((want < 0) ? ref_pixel(px, py, th) : 16'(want));
    tag_q.push_back(tag);
    if (tk && !fz) model_tick(vol);
  endtask

  task automatic drain();
    @(negedge clk);
    sample_tick = 1'b0;
    if (exp_q.size() > 0) check(tag_q.pop_front(), oled_data, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("por_oled", oled_data, 16'h0000);
    reset = 1'b0;
    model_reset();

    // Reset mid-run: output drops at once and stays low until the first clock after release.
    step(30, 20, 0, 1'b1, 1'b0, 25, -1, "pre_rst_tick");
    step(1, 1, 0, 1'b0, 1'b0, 25, 16'h07E0, "pre_rst_border");
    drain();
    #2 reset = 1'b1;
    #1 check("rst_async", oled_data, 16'h0000);
    @(negedge clk);
    check("rst_held", oled_data, 16'h0000);
    reset = 1'b0;
    model_reset();
    #1 check("rst_release", oled_data, 16'h0000);
    step(20, 17, 0, 1'b0, 1'b0, 0, 16'h0000, "rst_bar0_dark");
    step(40, 42, 0, 1'b0, 1'b0, 0, 16'h0000, "rst_no_marker");

    // Attack to 20: bars 0..3 lit, marker on bar 3.
    step(50, 50, 0, 1'b1, 1'b0, 20, -1, "attack_tick");
    step(20, 17, 0, 1'b0, 1'b0, 20, 16'h07E0, "bar0_low");
    step(20, 22, 0, 1'b0, 1'b0, 20, 16'h07E0, "bar1_low");
    step(20, 27, 0, 1'b0, 1'b0, 20, 16'hFFE0, "bar2_mid");
    step(20, 32, 0, 1'b0, 1'b0, 20, 16'hFFFF, "bar3_marker");
    step(20, 21, 0, 1'b0, 1'b0, 20, 16'h0000, "gap_row");
    step(20, 37, 0, 1'b0, 1'b0, 20, 16'h0000, "bar4_dark");
    step(17, 17, 0, 1'b0, 1'b0, 20, 16'h0000, "left_of_bars");
    step(78, 17, 0, 1'b0, 1'b0, 20, 16'h0000, "right_of_bars");
    step(77, 17, 0, 1'b0, 1'b0, 20, 16'h07E0, "bar_last_col");

    // Release with peak hold: level 19..15, peak 20,20,20,19,18.
    step(60, 60, 0, 1'b1, 1'b0, 0, -1, "rel_tick1");
    step(20, 32, 0, 1'b1, 1'b0, 0, 16'hFFFF, "rel_hold_marker");
    step(60, 60, 0, 1'b1, 1'b0, 0, -1, "rel_tick3");
    step(20, 32, 0, 1'b1, 1'b0, 0, 16'hFFFF, "rel_l17_p20");
    step(20, 27, 0, 1'b1, 1'b0, 0, 16'hFFE0, "rel_l16_p19");
    step(20, 27, 0, 1'b0, 1'b0, 0, 16'hFFFF, "rel_p18_marker");
    step(20, 32, 0, 1'b0, 1'b0, 0, 16'h0000, "rel_bar3_dark");

    // Freeze masks ticks entirely.
    for (int i = 0; i < 4; i++) step(20, 27, 0, 1'b1, 1'b1, 31, 16'hFFFF, "frz_marker");
    step(20, 42, 0, 1'b1, 1'b1, 31, 16'h0000, "frz_bar5_dark");
    step(20, 37, 0, 1'b1, 1'b0, 31, 16'h0000, "unfrz_tick");
    step(20, 42, 0, 1'b0, 1'b0, 31, 16'hFFFF, "bar5_marker");
    step(20, 37, 0, 1'b0, 1'b0, 31, 16'hF800, "bar4_high");
    step(20, 27, 0, 1'b0, 1'b0, 31, 16'hFFE0, "bar2_mid_full");

    // Themes, borders, out of range.
    step(1, 30, 1, 1'b0, 1'b0, 31, 16'hF81F, "t1_outer");
    step(50, 10, 1, 1'b0, 1'b0, 31, 16'hFFFF, "t1_bg");
    step(3, 30, 1, 1'b0, 1'b0, 31, 16'h001F, "t1_mid_border");
    step(5, 30, 1, 1'b0, 1'b0, 31, 16'hFC00, "t1_inner_border");
    step(20, 42, 1, 1'b0, 1'b0, 31, 16'h0000, "t1_marker");
    step(0, 0, 2, 1'b0, 1'b0, 31, 16'h001F, "t2_corner_bg");
    step(94, 62, 3, 1'b0, 1'b0, 31, 16'h8204, "t3_outer_corner");
    step(100, 1, 3, 1'b0, 1'b0, 31, 16'h5FFF, "t3_x_out_range");
    step(95, 63, 0, 1'b0, 1'b0, 31, 16'h0000, "t0_last_pixel");

    // Random run against the model.
    for (int n = 0; n < 10000; n++) begin
      int px, py;
      if ($urandom_range(1, 0) == 1) begin
        px = $urandom_range(79, 16);
        py = $urandom_range(48, 15);
      end else begin
        px = $urandom_range(127, 0);
        py = $urandom_range(63, 0);
      end
      step(px, py, $urandom_range(3, 0), ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
           $urandom_range(31, 0), -1, "rand_pixel");
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
